// File: rtl/arcade_input_pkg.sv
// Shared bit maps and coin FSM state type for the arcade input front end.
package arcade_input_pkg;

    localparam int unsigned JOY_W    = 16;
    localparam int unsigned PLAYER_W = 16;
    localparam int unsigned DSW_W    = 8;

    // hps_io joystick word bit positions (active-high)
    localparam int unsigned JOY_RIGHT = 0;
    localparam int unsigned JOY_LEFT  = 1;
    localparam int unsigned JOY_DOWN  = 2;
    localparam int unsigned JOY_UP    = 3;
    localparam int unsigned JOY_BTN1  = 4;
    localparam int unsigned JOY_BTN2  = 5;
    localparam int unsigned JOY_BTN3  = 6;
    localparam int unsigned JOY_START = 7;
    localparam int unsigned JOY_COIN  = 8;

    // cabinet PLAYER word bit positions (active-low)
    localparam int unsigned PL_COIN    = 0;
    localparam int unsigned PL_START   = 1;
    localparam int unsigned PL_BTN1    = 2;
    localparam int unsigned PL_BTN2    = 3;
    localparam int unsigned PL_BTN3    = 4;
    localparam int unsigned PL_SERVICE = 9;
    localparam int unsigned PL_LEFT    = 10;
    localparam int unsigned PL_RIGHT   = 11;
    localparam int unsigned PL_DOWN    = 12;
    localparam int unsigned PL_UP      = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } coin_state_t;

endpackage

// File: rtl/arcade_coin_shaper.sv
// Debounce for one synchronised input bit, optionally followed by a
// fixed-width coin pulse FSM with lockout until release.
module arcade_coin_shaper
    import arcade_input_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1024,
    parameter logic [23:0] PULSE_CYCLES    = 24'd1_000_000,
    parameter bit          PULSE_EN        = 1'b1
) (
    input  logic i_clk,
    input  logic RESETn,
    input  logic level,
    output logic active_c
);

    localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic        db;
    logic [15:0] db_cnt;

    // Debounced value only follows after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge i_clk) begin
        if (!RESETn) begin
            db     <= 1'b0;
            db_cnt <= 16'd0;
        end else if (level != db) begin
            if (db_cnt == DB_LAST) begin
                db     <= level;
                db_cnt <= 16'd0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end else begin
            db_cnt <= 16'd0;
        end
    end

    if (PULSE_EN) begin : g_pulse
        localparam logic [23:0] PC_LAST = PULSE_CYCLES - 24'd1;

        coin_state_t state, state_nx;
        logic [23:0] pcnt, pcnt_nx;
        logic        db_rise_c;

        assign db_rise_c = level && !db && (db_cnt == DB_LAST);

        always_ff @(posedge i_clk) begin
            if (!RESETn) begin
                state <= IDLE;
                pcnt  <= 24'd0;
            end else begin
                state <= state_nx;
                pcnt  <= pcnt_nx;
            end
        end

        // Pulse runs to completion regardless of the input; lockout until release
        always_comb begin
            state_nx = state;
            pcnt_nx  = pcnt;
            case (state)
                IDLE: begin
                    if (db_rise_c) begin
                        state_nx = PULSE;
                        pcnt_nx  = 24'd0;
                    end
                end
                PULSE: begin
                    if (pcnt == PC_LAST) begin
                        pcnt_nx  = 24'd0;
                        state_nx = db ? HOLD : IDLE;
                    end else begin
                        pcnt_nx = pcnt + 24'd1;
                    end
                end
                HOLD: begin
                    if (!db) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end

        assign active_c = (state == PULSE);
    end else begin : g_level
        assign active_c = db;
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Joystick/DIP front end between hps_io and an arcade core.
// Optional SOCD_CLEAN_EN: opposing directions pressed together read as released.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS       = 2,
    parameter int unsigned NUM_DSW           = 2,
    parameter logic [7:0]  DSW_INDEX         = 8'd254,
    parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd1024,
    parameter logic [23:0] COIN_PULSE_CYCLES = 24'd1_000_000
) (
    input  logic                      i_clk,
    input  logic                      RESETn,
    input  logic                      ioctl_wr,
    input  logic [7:0]                ioctl_index,
    input  logic [24:0]               ioctl_addr,
    input  logic [7:0]                ioctl_dout,
    input  logic [16*NUM_PLAYERS-1:0] joystick,
    input  logic                      service_sw,
    output logic [16*NUM_PLAYERS-1:0] PLAYER,
    output logic [8*NUM_DSW-1:0]      DSW,
    output logic                      dsw_valid
);

    logic [16*NUM_PLAYERS-1:0] joy_meta, joy_sync, player_c;
    logic                      svc_meta, svc_sync;

    always_ff @(posedge i_clk) begin
        if (!RESETn) begin
            joy_meta <= '0;
            joy_sync <= '0;
            svc_meta <= 1'b0;
            svc_sync <= 1'b0;
        end else begin
            joy_meta <= joystick;
            joy_sync <= joy_meta;
            svc_meta <= service_sw;
            svc_sync <= svc_meta;
        end
    end

    for (genvar p = 0; p < int'(NUM_PLAYERS); p++) begin : g_player
        logic [JOY_W-1:0]    js;
        logic [PLAYER_W-1:0] word_c;
        logic right_c, left_c, up_c, down_c, svc_c, coin_c, start_c;
        logic unused_js;

        assign js        = joy_sync[JOY_W*p +: JOY_W];
        assign unused_js = &{1'b0, js[15:9]};
        assign svc_c     = (p == 0) ? svc_sync : 1'b0;

`ifdef SOCD_CLEAN_EN
        assign right_c = js[JOY_RIGHT] & ~js[JOY_LEFT];
        assign left_c  = js[JOY_LEFT]  & ~js[JOY_RIGHT];
        assign up_c    = js[JOY_UP]    & ~js[JOY_DOWN];
        assign down_c  = js[JOY_DOWN]  & ~js[JOY_UP];
`else
        assign right_c = js[JOY_RIGHT];
        assign left_c  = js[JOY_LEFT];
        assign up_c    = js[JOY_UP];
        assign down_c  = js[JOY_DOWN];
`endif

        arcade_coin_shaper #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_CYCLES    (COIN_PULSE_CYCLES),
            .PULSE_EN        (1'b1)
        ) u_coin (
            .i_clk    (i_clk),
            .RESETn   (RESETn),
            .level    (js[JOY_COIN]),
            .active_c (coin_c)
        );

        arcade_coin_shaper #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_CYCLES    (COIN_PULSE_CYCLES),
            .PULSE_EN        (1'b0)
        ) u_start (
            .i_clk    (i_clk),
            .RESETn   (RESETn),
            .level    (js[JOY_START]),
            .active_c (start_c)
        );

        // Unused cabinet bits idle high
        always_comb begin
            word_c             = '1;
            word_c[PL_UP]      = ~up_c;
            word_c[PL_DOWN]    = ~down_c;
            word_c[PL_RIGHT]   = ~right_c;
            word_c[PL_LEFT]    = ~left_c;
            word_c[PL_SERVICE] = ~svc_c;
            word_c[PL_BTN3]    = ~js[JOY_BTN3];
            word_c[PL_BTN2]    = ~js[JOY_BTN2];
            word_c[PL_BTN1]    = ~js[JOY_BTN1];
            word_c[PL_START]   = ~start_c;
            word_c[PL_COIN]    = ~coin_c;
        end

        assign player_c[PLAYER_W*p +: PLAYER_W] = word_c;
    end

    always_ff @(posedge i_clk) begin
        if (!RESETn) PLAYER <= '1;
        else         PLAYER <= player_c;
    end

    // DIP state must survive RESETn (held during download); power-up values only
    logic [DSW_W-1:0]       bank [NUM_DSW] = '{default: 8'h00};
    logic [NUM_DSW-1:0]     written        = '0;
    logic [8*NUM_DSW-1:0]   dsw_r          = '1;
    logic                   dsw_valid_r    = 1'b0;
    logic                   dsw_hit_c;

    assign dsw_hit_c = ioctl_wr && (ioctl_index == DSW_INDEX) && (ioctl_addr[24:3] == 22'd0);

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < int'(NUM_DSW); b++) begin
            if (dsw_hit_c && (ioctl_addr[2:0] == 3'(b))) begin
                bank[b]    <= ioctl_dout;
                written[b] <= 1'b1;
            end
            dsw_r[DSW_W*b +: DSW_W] <= ~bank[b];
        end
        dsw_valid_r <= &written;
    end

    assign DSW       = dsw_r;
    assign dsw_valid = dsw_valid_r;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl with a short debounce and coin pulse.
module tb_arcade_input_ctrl;

    localparam int unsigned NP = 2;
    localparam int unsigned ND = 2;

    logic            i_clk       = 1'b0;
    logic            RESETn      = 1'b0;
    logic            ioctl_wr    = 1'b0;
    logic [7:0]      ioctl_index = 8'd0;
    logic [24:0]     ioctl_addr  = 25'd0;
    logic [7:0]      ioctl_dout  = 8'd0;
    logic [16*NP-1:0] joystick   = '0;
    logic            service_sw  = 1'b0;
    logic [16*NP-1:0] PLAYER;
    logic [8*ND-1:0] DSW;
    logic            dsw_valid;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    always #5 i_clk = ~i_clk;

    arcade_input_ctrl #(
        .NUM_PLAYERS       (NP),
        .NUM_DSW           (ND),
        .DSW_INDEX         (8'd254),
        .DEBOUNCE_CYCLES   (16'd4),
        .COIN_PULSE_CYCLES (24'd8)
    ) dut (
        .i_clk       (i_clk),
        .RESETn      (RESETn),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .joystick    (joystick),
        .service_sw  (service_sw),
        .PLAYER      (PLAYER),
        .DSW         (DSW),
        .dsw_valid   (dsw_valid)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic dip_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        tick(1);
        ioctl_wr    = 1'b0;
    endtask

    task automatic test_reset;
        RESETn = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_FFFF);
        exp_q.push_back(32'h0);
        tick(3);
        n_checks++; exp = exp_q.pop_front();
        if (PLAYER !== exp) begin n_fail++; $display("FAIL reset_player: got %h expected %h", PLAYER, exp); end
        n_checks++; exp = exp_q.pop_front();
        if (DSW !== exp[15:0]) begin n_fail++; $display("FAIL reset_dsw: got %h expected %h", DSW, exp[15:0]); end
        n_checks++; exp = exp_q.pop_front();
        if (dsw_valid !== exp[0]) begin n_fail++; $display("FAIL reset_valid: got %b expected %b", dsw_valid, exp[0]); end
        RESETn = 1'b1;
        exp_q.push_back(32'hFFFF_FFFF);
        tick(4);
        n_checks++; exp = exp_q.pop_front();
        if (PLAYER !== exp) begin n_fail++; $display("FAIL idle_player: got %h expected %h", PLAYER, exp); end
    endtask

    task automatic test_dip_load;
        dip_write(8'd254, 25'd0, 8'hA5);
        dip_write(8'd254, 25'd1, 8'h3C);
        exp_q.push_back(32'h0);
        n_checks++; exp = exp_q.pop_front();
        if (dsw_valid !== exp[0]) begin n_fail++; $display("FAIL dip_valid_early: got %b expected %b", dsw_valid, exp[0]); end
        exp_q.push_back(32'h1);
        exp_q.push_back(32'hC35A);
        tick(1);
        n_checks++; exp = exp_q.pop_front();
        if (dsw_valid !== exp[0]) begin n_fail++; $display("FAIL dip_valid: got %b expected %b", dsw_valid, exp[0]); end
        n_checks++; exp = exp_q.pop_front();
        if (DSW !== exp[15:0]) begin n_fail++; $display("FAIL dip_load: got %h expected %h", DSW, exp[15:0]); end
        // out-of-range bank, nonzero upper address, wrong index: all ignored
        dip_write(8'd254, 25'd2, 8'h11);
        dip_write(8'd254, 25'd8, 8'h22);
        dip_write(8'd0,   25'd0, 8'h33);
        exp_q.push_back(32'hC35A);
        tick(2);
        n_checks++; exp = exp_q.pop_front();
        if (DSW !== exp[15:0]) begin n_fail++; $display("FAIL dip_ignored: got %h expected %h", DSW, exp[15:0]); end
    endtask

    task automatic test_dip_survives_reset;
        RESETn = 1'b0;
        exp_q.push_back(32'hC35A);
        exp_q.push_back(32'h1);
        tick(10);
        n_checks++; exp = exp_q.pop_front();
        if (DSW !== exp[15:0]) begin n_fail++; $display("FAIL dip_in_reset: got %h expected %h", DSW, exp[15:0]); end
        n_checks++; exp = exp_q.pop_front();
        if (dsw_valid !== exp[0]) begin n_fail++; $display("FAIL valid_in_reset: got %b expected %b", dsw_valid, exp[0]); end
        RESETn = 1'b1;
        exp_q.push_back(32'hC35A);
        tick(3);
        n_checks++; exp = exp_q.pop_front();
        if (DSW !== exp[15:0]) begin n_fail++; $display("FAIL dip_after_reset: got %h expected %h", DSW, exp[15:0]); end
    endtask

    task automatic test_dip_rewrite;
        dip_write(8'd254, 25'd1, 8'h00);
        exp_q.push_back(32'hFF5A);
        tick(1);
        n_checks++; exp = exp_q.pop_front();
        if (DSW !== exp[15:0]) begin n_fail++; $display("FAIL dip_rewrite: got %h expected %h", DSW, exp[15:0]); end
    endtask

    task automatic test_directions;
        joystick   = {16'h0030, 16'h0009};
        service_sw = 1'b1;
        exp_q.push_back(32'hFFFF);
        exp_q.push_back(32'hD5FF);
        exp_q.push_back(32'hFFF3);
        tick(2);
        n_checks++; exp = exp_q.pop_front();
        if (PLAYER[15:0] !== exp[15:0]) begin n_fail++; $display("FAIL dir_latency: got %h expected %h", PLAYER[15:0], exp[15:0]); end
        tick(1);
        n_checks++; exp = exp_q.pop_front();
        if (PLAYER[15:0] !== exp[15:0]) begin n_fail++; $display("FAIL dir_p0: got %h expected %h", PLAYER[15:0], exp[15:0]); end
        n_checks++; exp = exp_q.pop_front();
        if (PLAYER[31:16] !== exp[15:0]) begin n_fail++; $display("FAIL dir_p1: got %h expected %h", PLAYER[31:16], exp[15:0]); end
        joystick   = '0;
        service_sw = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF);
        tick(4);
        n_checks++; exp = exp_q.pop_front();
        if (PLAYER !== exp) begin n_fail++; $display("FAIL dir_clear: got %h expected %h", PLAYER, exp); end
    endtask

    task automatic test_socd;
        logic [15:0] pat [3];
        logic [15:0] want [3];
        pat[0] = 16'h0003; pat[1] = 16'h000C; pat[2] = 16'h0007;
`ifdef SOCD_CLEAN_EN
        want[0] = 16'hFFFF; want[1] = 16'hFFFF; want[2] = 16'hEFFF;
`else
        want[0] = 16'hF3FF; want[1] = 16'hCFFF; want[2] = 16'hE3FF;
`endif
        for (int i = 0; i < 3; i++) begin
            joystick[15:0] = pat[i];
            exp_q.push_back({16'h0, want[i]});
            tick(3);
            n_checks++; exp = exp_q.pop_front();
            if (PLAYER[15:0] !== exp[15:0]) begin
                n_fail++; $display("FAIL socd_%0d: got %h expected %h", i, PLAYER[15:0], exp[15:0]);
            end
        end
        joystick = '0;
        tick(4);
    endtask

    task automatic test_coin_pulse;
        int zeros;
        for (int rep = 0; rep < 2; rep++) begin
            zeros = 0;
            joystick[8] = 1'b1;
            exp_q.push_back(32'd8);
            exp_q.push_back(32'd1);
            for (int i = 0; i < 40; i++) begin
                tick(1);
                if (PLAYER[0] === 1'b0) zeros++;
            end
            n_checks++; exp = exp_q.pop_front();
            if (zeros !== int'(exp)) begin n_fail++; $display("FAIL coin_width_%0d: got %0d expected %0d", rep, zeros, exp); end
            n_checks++; exp = exp_q.pop_front();
            if (PLAYER[0] !== exp[0]) begin n_fail++; $display("FAIL coin_hold_%0d: got %b expected %b", rep, PLAYER[0], exp[0]); end
            joystick[8] = 1'b0;
            zeros = 0;
            exp_q.push_back(32'd0);
            for (int i = 0; i < 20; i++) begin
                tick(1);
                if (PLAYER[0] === 1'b0) zeros++;
            end
            n_checks++; exp = exp_q.pop_front();
            if (zeros !== int'(exp)) begin n_fail++; $display("FAIL coin_release_%0d: got %0d expected %0d", rep, zeros, exp); end
        end
    endtask

    task automatic test_coin_short_press;
        int zeros = 0;
        joystick[8] = 1'b1;
        exp_q.push_back(32'd8);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (i == 8) joystick[8] = 1'b0;
            if (PLAYER[0] === 1'b0) zeros++;
        end
        n_checks++; exp = exp_q.pop_front();
        if (zeros !== int'(exp)) begin n_fail++; $display("FAIL coin_short: got %0d expected %0d", zeros, exp); end
    endtask

    task automatic test_p1_coin;
        int z0 = 0;
        int z1 = 0;
        joystick[24] = 1'b1;
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd0);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (PLAYER[16] === 1'b0) z1++;
            if (PLAYER[0] === 1'b0) z0++;
        end
        joystick[24] = 1'b0;
        n_checks++; exp = exp_q.pop_front();
        if (z1 !== int'(exp)) begin n_fail++; $display("FAIL p1_coin: got %0d expected %0d", z1, exp); end
        n_checks++; exp = exp_q.pop_front();
        if (z0 !== int'(exp)) begin n_fail++; $display("FAIL p1_coin_iso: got %0d expected %0d", z0, exp); end
        tick(20);
    endtask

    task automatic test_glitch;
        int zc = 0;
        int zs = 0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        joystick[8] = 1'b1;
        joystick[7] = 1'b1;
        for (int i = 0; i < 23; i++) begin
            tick(1);
            if (i == 2) begin joystick[8] = 1'b0; joystick[7] = 1'b0; end
            if (PLAYER[0] === 1'b0) zc++;
            if (PLAYER[1] === 1'b0) zs++;
        end
        n_checks++; exp = exp_q.pop_front();
        if (zc !== int'(exp)) begin n_fail++; $display("FAIL coin_glitch: got %0d expected %0d", zc, exp); end
        n_checks++; exp = exp_q.pop_front();
        if (zs !== int'(exp)) begin n_fail++; $display("FAIL start_glitch: got %0d expected %0d", zs, exp); end
    endtask

    task automatic test_start_level;
        joystick[7] = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        tick(12);
        n_checks++; exp = exp_q.pop_front();
        if (PLAYER[1] !== exp[0]) begin n_fail++; $display("FAIL start_held: got %b expected %b", PLAYER[1], exp[0]); end
        n_checks++; exp = exp_q.pop_front();
        if (PLAYER[0] !== exp[0]) begin n_fail++; $display("FAIL start_no_coin: got %b expected %b", PLAYER[0], exp[0]); end
        joystick[7] = 1'b0;
        exp_q.push_back(32'h1);
        tick(12);
        n_checks++; exp = exp_q.pop_front();
        if (PLAYER[1] !== exp[0]) begin n_fail++; $display("FAIL start_release: got %b expected %b", PLAYER[1], exp[0]); end
    endtask

    initial begin
        test_reset();
        test_dip_load();
        test_dip_survives_reset();
        test_dip_rewrite();
        test_directions();
        test_socd();
        test_coin_pulse();
        test_coin_short_press();
        test_p1_coin();
        test_glitch();
        test_start_level();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
